// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and load-extension helpers for data_mem_responder
package dmem_pkg;
    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2, DWORD = 2'd3} size_e;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

    function automatic logic [6:0] ext_width(size_e s);
        return 7'd8 << s;
    endfunction

    function automatic logic [63:0] extend(logic [63:0] raw, size_e s, logic uns);
        logic [63:0] mask;
        logic [5:0] top;
        mask = (s == DWORD) ? '1 : ((64'd1 << ext_width(s)) - 64'd1);
        top = 6'(ext_width(s) - 7'd1);
        return (raw & mask) | ((raw[top] && !uns) ? ~mask : '0);
    endfunction
endpackage

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: byte storage with 8-lane byte-enable write, 8-byte read, wrap-around indexing
module dmem_byte_array #(
    parameter int DEPTH_BYTES = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we,
    input  logic [$clog2(DEPTH_BYTES)-1:0] addr,
    input  logic [63:0]                    wdata,
    input  logic [7:0]                     wbe,
    output logic [63:0]                    rdata
);
    localparam int AW = $clog2(DEPTH_BYTES);

    logic [7:0] mem_q [DEPTH_BYTES];
    logic [7:0] mem_d [DEPTH_BYTES];

    // Lane i lands at addr+i; AW-bit arithmetic wraps past the top byte to 0
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < 8; i++)
            if (we && wbe[i]) mem_d[addr + AW'(i)] = wdata[8*i +: 8];
    end

    // Little-endian gather of the 8 bytes starting at addr, wrapping the same way
    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) rdata[8*i +: 8] = mem_q[addr + AW'(i)];
    end

    // Storage register with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mem_q <= '{default: '0};
        else        mem_q <= mem_d;
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder with fixed latency.
// Define DMEM_MISALIGN_CHECK_EN to reject misaligned accesses with rsp_err.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = $clog2(LATENCY + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            live_q, live_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [63:0]     wdata_q, wdata_d;
    size_e           size_q, size_d;
    logic            uns_q, uns_d;
    logic [63:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            idle, accept, enter_resp, mis, mem_we;
    logic            a_we, a_uns;
    logic [AW-1:0]   a_addr;
    logic [63:0]     a_wdata, raw;
    size_e           a_size;
    logic [7:0]      size_be;
    logic            unused_addr;

    assign unused_addr = ^req_addr[63:AW];
    assign idle        = state_q == IDLE;
    assign req_ready   = live_q && idle;
    assign accept      = req_valid && req_ready;
    assign rsp_valid   = state_q == RESP;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;

    // Access fields come straight from the request when RESP is entered on the accept edge
    always_comb begin
        a_we    = idle ? req_we : we_q;
        a_addr  = idle ? req_addr[AW-1:0] : addr_q;
        a_wdata = idle ? req_wdata : wdata_q;
        a_size  = idle ? size_e'(req_size) : size_q;
        a_uns   = idle ? req_unsigned : uns_q;
        size_be = a_size == BYTE ? 8'h01 : a_size == HALF ? 8'h03 : a_size == WORD ? 8'h0F : 8'hFF;
        mem_we  = enter_resp && a_we && !mis;
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign mis = |({1'b0, a_addr[2:0]} & ((4'd1 << a_size) - 4'd1));
`else
    assign mis = 1'b0;
`endif

    dmem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .addr  (a_addr),
        .wdata (a_wdata),
        .wbe   (size_be),
        .rdata (raw)
    );

    // Next-state, request latching and response capture
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        live_d     = 1'b1;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                we_d    = req_we;
                addr_d  = req_addr[AW-1:0];
                wdata_d = req_wdata;
                size_d  = size_e'(req_size);
                uns_d   = req_unsigned;
                cnt_d   = CW'(1);
                if (LATENCY > 1) state_d = WAIT;
                else begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            WAIT: if (cnt_q >= CW'(LATENCY - 1)) begin
                state_d    = RESP;
                cnt_d      = '0;
                enter_resp = 1'b1;
            end else cnt_d = cnt_q + CW'(1);
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            err_d   = mis;
            rdata_d = (a_we || mis) ? '0 : extend(raw, a_size, a_uns);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            live_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= BYTE;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= live_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule
